// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux router.
// Optional build macro: DEMUX_CNT_EN (per-channel delivered-word counters).
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  // Channel occupancy; the encoding doubles as the channel's valid bit.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/demux_slot.sv
// One single-entry output channel of the demux router: valid bit, data
// register and, when DEMUX_CNT_EN is defined, a wrapping delivered-word counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = 8
`ifdef DEMUX_CNT_EN
  ,
  parameter int CW = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CW-1:0] cnt
`endif
);

  chan_state_e state;
  chan_state_e state_nxt;

  // Occupancy register; reset empties the channel immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy: a load always wins, so drain+load keeps the slot full.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL: begin
        if (load)           state_nxt = FULL;
        else if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Data register; only written on load, otherwise held (also while empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_data <= '0;
    else if (load) out_data <= load_data;
  end

`ifdef DEMUX_CNT_EN
  // Delivered-word counter; wraps naturally at 2^CW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (out_valid && out_ready) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes. Each output
// channel is an independent single-entry buffer, so a stalled consumer only
// blocks words addressed to it.
// Optional build macro: DEMUX_CNT_EN adds the cnt port (per-channel counters).
module demux_router
  import demux_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SEL_W-1:0]    in_sel,
  output logic [NCH-1:0]      out_valid,
  input  logic [NCH-1:0]      out_ready,
  output logic [NCH*DW-1:0]   out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [NCH*CW-1:0]   cnt
`endif
);

  logic           accept;
  logic [NCH-1:0] load;

  // The selected channel can take a word if it is empty or draining this edge.
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
  end

  // Select decode: only the addressed channel loads on an accepted word.
  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = accept && (in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(
      .DW(DW)
`ifdef DEMUX_CNT_EN
      ,
      .CW(CW)
`endif
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*DW +: DW])
`ifdef DEMUX_CNT_EN
      ,
      .cnt       (cnt[g*CW +: CW])
`endif
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router (DW=8, CW=8).
module tb_demux_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_CNT_EN
  logic [31:0] cnt;
`endif

  int checks = 0;
  int errors = 0;
  int acc;

  demux_router #(.DW(8), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hFF; out_ready = 4'b0000;
    #1;
    // Reset held with a valid word present: nothing may be captured.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_valid", {28'd0, out_valid}, 32'h0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_ready", {31'd0, in_ready}, 32'h1);
`ifdef DEMUX_CNT_EN
      chk("rst_cnt", cnt, 32'h0);
`endif
    end

    // First word after reset release, latency 1.
    rst = 1'b0; in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", {28'd0, out_valid}, 32'h4);
    chk("first_data", {24'd0, out_data[23:16]}, 32'hA5);

    // Drain channel 2, then fill all four channels with consumers stalled.
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("drain2_valid", {28'd0, out_valid}, 32'h0);
    chk("drain2_hold", {24'd0, out_data[23:16]}, 32'hA5);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'(8'h11 * (k + 1));
      #1;
      chk("fill_ready", {31'd0, in_ready}, 32'h1);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_valid", {28'd0, out_valid}, 32'hF);
    chk("fill_data", out_data, 32'h44332211);

    // Fifth word to a full stalled channel is refused.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h55;
    #1;
    chk("full_ready", {31'd0, in_ready}, 32'h0);
    tick();
    chk("full_hold", {24'd0, out_data[15:8]}, 32'h22);
    chk("full_valid", {28'd0, out_valid}, 32'hF);

    // Drain and load channel 3 on the same edge: no bubble.
    in_sel = 2'd3; in_data = 8'h77; out_ready = 4'b1000;
    #1;
    chk("pass_ready", {31'd0, in_ready}, 32'h1);
    tick();
    chk("pass_valid", {28'd0, out_valid}, 32'hF);
    chk("pass_data", {24'd0, out_data[31:24]}, 32'h77);

    // Ten back-to-back words through channel 3.
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'(8'h80 + k);
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("stream_count", acc, 32'd10);
    chk("stream_last", {24'd0, out_data[31:24]}, 32'h89);
    chk("stream_valid", {31'd0, out_valid[3]}, 32'h1);

    // Channel 0 stalled, channel 1 draining: alternate selects.
    out_ready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      in_sel = 2'd0; in_data = 8'(8'hC0 + k);
      #1;
      chk("hol_block", {31'd0, in_ready}, 32'h0);
      tick();
      in_sel = 2'd1; in_data = 8'(8'hD0 + k);
      #1;
      chk("hol_pass", {31'd0, in_ready}, 32'h1);
      tick();
      chk("hol_ch1", {24'd0, out_data[15:8]}, 32'(8'hD0 + k));
    end
    chk("hol_ch0", {24'd0, out_data[7:0]}, 32'h11);
    chk("hol_v0", {31'd0, out_valid[0]}, 32'h1);

    // Refill to all-full, then assert reset asynchronously mid-cycle.
    out_ready = 4'b0000;
    in_sel = 2'd2; in_data = 8'h62;
    tick();
    in_valid = 1'b0;
    chk("prerst_valid", {28'd0, out_valid}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", {28'd0, out_valid}, 32'h0);
    chk("async_data", out_data, 32'h0);
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("post_valid", {28'd0, out_valid}, 32'h1);
    chk("post_data", {24'd0, out_data[7:0]}, 32'h5A);

`ifdef DEMUX_CNT_EN
    // 257 words through channel 2; counter wraps to 1.
    out_ready = 4'b0100; in_valid = 1'b1; in_sel = 2'd2;
    for (int k = 0; k < 257; k++) begin
      in_data = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    chk("cnt_ch2", {24'd0, cnt[23:16]}, 32'h1);
    chk("cnt_others", {cnt[31:24], 8'd0, cnt[15:0]}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
